// File: rtl/seg_scan_if.sv
// seg_scan_if: update handshake and shared segment-bus signals of seg_scan_sched.
interface seg_scan_if #(parameter int DIGITS = 6);
    logic                upd_req;
    logic [4*DIGITS-1:0] upd_data;
    logic                upd_ack;
    logic [2:0]          sel;
    logic [7:0]          seg;
    logic                frame_start;
    modport master (output upd_req, upd_data, input upd_ack, sel, seg, frame_start);
    modport slave  (input upd_req, upd_data, output upd_ack, sel, seg, frame_start);
endinterface

// File: rtl/seg_scan_sched.sv
// seg_scan_sched: scans DIGITS digits over one segment bus, committing new data only at frame boundaries.
// Define SEG_LZ_SUPPRESS_EN to blank leading-zero digits.
module seg_scan_sched #(
    parameter int DIGITS = 6,
    parameter int DWELL  = 50000,
    parameter int BLANK  = 500
) (
    input logic       clk,
    input logic       rst,
    seg_scan_if.slave bus
);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2((DWELL > BLANK ? DWELL : BLANK) + 1);
    localparam logic [7:0] DEC [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    typedef enum logic {S_SHOW, S_BLANK} state_t;
    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d, nidx;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [4*DIGITS-1:0] act_q, act_d;
    logic [2:0]          sel_q, sel_d;
    logic [7:0]          seg_q, seg_d;
    logic                ack_q, ack_d, fs_q, fs_d;
`ifdef SEG_LZ_SUPPRESS_EN
    logic [DIGITS-1:0]   blk_q, blk_d;
    // Digit i is blank when it and every digit above it are zero; digit 0 never blanks.
    function automatic logic [DIGITS-1:0] lz_flags(input logic [4*DIGITS-1:0] v);
        logic z;
        z = 1'b1;
        lz_flags = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            z = z && (v[4*i +: 4] == 4'h0);
            lz_flags[i] = z;
        end
    endfunction
`endif
    always_comb begin
        nidx    = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + CW'(1);
        act_d   = act_q;
        sel_d   = sel_q;
        seg_d   = seg_q;
        ack_d   = 1'b0;
        fs_d    = 1'b0;
`ifdef SEG_LZ_SUPPRESS_EN
        blk_d   = blk_q;
`endif
        if (state_q == S_SHOW) begin
            if (cnt_q == CW'(DWELL - 1)) begin
                state_d = S_BLANK;
                cnt_d   = '0;
                seg_d   = 8'hFF;
            end
        end else if (cnt_q == CW'(BLANK - 1)) begin
            state_d = S_SHOW;
            cnt_d   = '0;
            idx_d   = nidx;
            sel_d   = 3'(nidx);
            fs_d    = idx_q == IW'(DIGITS - 1);
            if (fs_d && bus.upd_req && !ack_q) begin
                act_d = bus.upd_data;
                ack_d = 1'b1;
`ifdef SEG_LZ_SUPPRESS_EN
                blk_d = lz_flags(bus.upd_data);
`endif
            end
            // Decode from the just-committed buffer so digit 0 of a new frame shows new data.
            seg_d = DEC[act_d[4*nidx +: 4]];
`ifdef SEG_LZ_SUPPRESS_EN
            seg_d = blk_d[nidx] ? 8'hFF : seg_d;
`endif
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_BLANK;
            idx_q   <= IW'(DIGITS - 1);
            cnt_q   <= '0;
            act_q   <= '0;
            sel_q   <= '0;
            seg_q   <= 8'hFF;
            ack_q   <= 1'b0;
            fs_q    <= 1'b0;
`ifdef SEG_LZ_SUPPRESS_EN
            blk_q   <= lz_flags('0);
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
            ack_q   <= ack_d;
            fs_q    <= fs_d;
`ifdef SEG_LZ_SUPPRESS_EN
            blk_q   <= blk_d;
`endif
        end
    end
    assign bus.upd_ack     = ack_q;
    assign bus.sel         = sel_q;
    assign bus.seg         = seg_q;
    assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_seg_scan_sched.sv
// tb_seg_scan_sched: randomized checks of seg_scan_sched against a time-based frame model.
module tb_seg_scan_sched;
`ifdef SEG_LZ_SUPPRESS_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif
    localparam logic [7:0] DEC_T [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cmp = 0;
    int   bad = 0;
    seg_scan_if #(.DIGITS(6)) bus();
    seg_scan_sched #(.DIGITS(6), .DWELL(4), .BLANK(2)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    // Model: t edges since reset release; frames of 36 cycles begin at t=2, each digit 4 shown + 2 blank.
    int          t, m_q;
    logic [23:0] m_val;
    logic        m_ack, m_fs, m_ack_n;
    logic [2:0]  m_sel;
    logic [7:0]  m_seg;
    function automatic logic [7:0] digit_seg(input logic [23:0] v, input int d);
        logic [23:0] hi;
        hi = v >> (4 * d);
        if (LZ && d > 0 && hi == 24'h0) return 8'hFF;
        return DEC_T[hi[3:0]];
    endfunction
    always @(posedge clk) begin
        if (rst) begin
            t = 0; m_q = -1; m_val = '0; m_ack = 1'b0; m_fs = 1'b0; m_sel = 3'd0; m_seg = 8'hFF;
        end else begin
            t++;
            m_fs = 1'b0;
            m_ack_n = 1'b0;
            if (t >= 2) begin
                m_q = (t - 2) % 36;
                if (m_q == 0) begin
                    m_fs = 1'b1;
                    if (bus.upd_req && !m_ack) begin
                        m_val = bus.upd_data;
                        m_ack_n = 1'b1;
                    end
                end
                m_sel = 3'(m_q / 6);
                m_seg = (m_q % 6 < 4) ? digit_seg(m_val, m_q / 6) : 8'hFF;
            end
            m_ack = m_ack_n;
        end
    end
    logic [12:0] dut_v, exp_v;
    assign dut_v = {bus.sel, bus.seg, bus.upd_ack, bus.frame_start};
    assign exp_v = {m_sel, m_seg, m_ack, m_fs};

    task automatic send(input logic [23:0] d, output bit ok);
        int n = 0;
        bus.upd_data = d;
        bus.upd_req = 1'b1;
        do begin @(negedge clk); n++; end while (!bus.upd_ack && n < 80);
        ok = bus.upd_ack;
        bus.upd_req = 1'b0;
    endtask

    task automatic test_reset;
        bus.upd_req = 1'b0;
        bus.upd_data = '0;
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk); cmp++;
            if (dut_v !== {3'd0, 8'hFF, 2'b00}) begin
                bad++; $display("FAIL reset_hold got=%h want=%h", dut_v, {3'd0, 8'hFF, 2'b00});
            end
        end
        rst = 1'b0;
        @(negedge clk); cmp++;
        if (dut_v !== {3'd0, 8'hFF, 2'b00}) begin
            bad++; $display("FAIL reset_blank got=%h want=%h", dut_v, {3'd0, 8'hFF, 2'b00});
        end
        @(negedge clk); cmp++;
        if (dut_v !== {3'd0, 8'hC0, 2'b01}) begin
            bad++; $display("FAIL first_frame got=%h want=%h", dut_v, {3'd0, 8'hC0, 2'b01});
        end
    endtask

    task automatic test_mid_frame;
        logic [7:0] want [6] = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
        int n = 0;
        do begin @(negedge clk); n++; end while (!bus.frame_start && n < 100);
        cmp++;
        if (bus.frame_start !== 1'b1) begin bad++; $display("FAIL mid_sync got=%b want=1", bus.frame_start); end
        repeat (10) @(negedge clk);
        bus.upd_data = 24'h123456;
        bus.upd_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk); n++; cmp++;
            if (dut_v !== exp_v) begin bad++; $display("FAIL mid_wait got=%h want=%h", dut_v, exp_v); end
        end while (!bus.upd_ack && n < 60);
        cmp++;
        if ({bus.upd_ack, bus.frame_start, bus.seg} !== {2'b11, 8'h82}) begin
            bad++; $display("FAIL mid_commit got=%h want=%h", {bus.upd_ack, bus.frame_start, bus.seg}, {2'b11, 8'h82});
        end
        bus.upd_req = 1'b0;
        for (int c = 1; c < 36; c++) begin
            @(negedge clk); cmp++;
            if (dut_v !== exp_v) begin bad++; $display("FAIL mid_frame c=%0d got=%h want=%h", c, dut_v, exp_v); end
            if (c % 6 < 4) begin
                cmp++;
                if (bus.seg !== want[c/6]) begin bad++; $display("FAIL mid_digit c=%0d got=%h want=%h", c, bus.seg, want[c/6]); end
            end
        end
    endtask

    task automatic test_boundary_race;
        logic [23:0] d;
        int n = 0;
        do begin @(negedge clk); n++; end while (!bus.frame_start && n < 100);
        repeat (35) @(negedge clk);
        d = 24'($urandom);
        bus.upd_data = d;
        bus.upd_req = 1'b1;
        @(negedge clk); cmp++;
        if ({bus.upd_ack, bus.frame_start, bus.seg} !== {2'b11, DEC_T[d[3:0]]}) begin
            bad++; $display("FAIL race_commit got=%h want=%h", {bus.upd_ack, bus.frame_start, bus.seg}, {2'b11, DEC_T[d[3:0]]});
        end
        bus.upd_req = 1'b0;
        repeat (36) begin
            @(negedge clk); cmp++;
            if (dut_v !== exp_v) begin bad++; $display("FAIL race_frame got=%h want=%h", dut_v, exp_v); end
        end
    endtask

    task automatic test_sticky;
        int pulses = 0;
        logic prev = 1'b0;
        bus.upd_data = 24'($urandom);
        bus.upd_req = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk); cmp++;
            if (dut_v !== exp_v || (bus.upd_ack && prev)) begin
                bad++; $display("FAIL sticky c=%0d got=%h want=%h prev_ack=%b", c, dut_v, exp_v, prev);
            end
            pulses += int'(bus.upd_ack);
            prev = bus.upd_ack;
        end
        bus.upd_req = 1'b0;
        cmp++;
        if (pulses < 2 || pulses > 3) begin bad++; $display("FAIL sticky_count got=%0d want=2..3", pulses); end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        do begin @(negedge clk); n++; end while (!bus.frame_start && n < 100);
        repeat (18) @(negedge clk);
        bus.upd_data = 24'($urandom) | 24'h1;
        bus.upd_req = 1'b1;
        rst = 1'b1;
        @(negedge clk); cmp++;
        if (dut_v !== {3'd0, 8'hFF, 2'b00}) begin
            bad++; $display("FAIL rst_mid got=%h want=%h", dut_v, {3'd0, 8'hFF, 2'b00});
        end
        bus.upd_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); cmp++;
            if (dut_v !== exp_v) begin bad++; $display("FAIL rst_after got=%h want=%h", dut_v, exp_v); end
            if (bus.frame_start) begin
                cmp++;
                if (bus.seg !== 8'hC0) begin bad++; $display("FAIL rst_zero got=%h want=c0", bus.seg); end
            end
        end
    endtask

    task automatic test_lz;
        bit ok;
        send(24'h000042, ok);
        cmp++;
        if (!ok || bus.seg !== 8'hA4) begin bad++; $display("FAIL lz_commit ack=%b got=%h want=a4", ok, bus.seg); end
        for (int c = 1; c < 36; c++) begin
            @(negedge clk); cmp++;
            if (dut_v !== exp_v) begin bad++; $display("FAIL lz_frame got=%h want=%h", dut_v, exp_v); end
            if (c == 7 || c == 13 || c == 30) begin
                cmp++;
                if (bus.seg !== (c == 7 ? 8'h99 : (LZ ? 8'hFF : 8'hC0))) begin
                    bad++; $display("FAIL lz_digit c=%0d got=%h want=%h", c, bus.seg, (c == 7 ? 8'h99 : (LZ ? 8'hFF : 8'hC0)));
                end
            end
        end
        send(24'h0, ok);
        cmp++;
        if (!ok || bus.seg !== 8'hC0) begin bad++; $display("FAIL lz_zero ack=%b got=%h want=c0", ok, bus.seg); end
        for (int c = 1; c < 36; c++) begin
            @(negedge clk); cmp++;
            if (dut_v !== exp_v) begin bad++; $display("FAIL lz_zero_frame got=%h want=%h", dut_v, exp_v); end
            if (c == 7) begin
                cmp++;
                if (bus.seg !== (LZ ? 8'hFF : 8'hC0)) begin
                    bad++; $display("FAIL lz_zero_digit got=%h want=%h", bus.seg, (LZ ? 8'hFF : 8'hC0));
                end
            end
        end
    endtask

    task automatic test_random;
        int n;
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(0, 40)) begin
                @(negedge clk); cmp++;
                if (dut_v !== exp_v) begin bad++; $display("FAIL rand_idle got=%h want=%h", dut_v, exp_v); end
            end
            bus.upd_data = ($urandom_range(0, 1) != 0) ? 24'($urandom) : 24'($urandom_range(0, 255));
            bus.upd_req = 1'b1;
            n = 0;
            do begin
                @(negedge clk); n++; cmp++;
                if (dut_v !== exp_v) begin bad++; $display("FAIL rand_req got=%h want=%h", dut_v, exp_v); end
            end while (!bus.upd_ack && n < 80);
            bus.upd_req = 1'b0;
        end
        repeat (36) begin
            @(negedge clk); cmp++;
            if (dut_v !== exp_v) begin bad++; $display("FAIL rand_tail got=%h want=%h", dut_v, exp_v); end
        end
    endtask

    initial begin
        test_reset;
        test_mid_frame;
        test_boundary_race;
        test_sticky;
        test_reset_mid;
        test_lz;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
